// File: rtl/mul_pkg.sv
// Shared types and constants for the mul_accum MAC accumulator slice.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int PROD_W    = 64;
  localparam int ACC_W_DEF = 72;
  localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/mul_acc_add.sv
// Combinational ACC_W adder with carry out.
// With MUL_ACCUM_SATURATE_EN defined the sum clamps to all-ones on a carry.
module mul_acc_add
  import mul_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [ACC_W-1:0] addend,
  output logic [ACC_W-1:0] sum,
  output logic             carry
);

  logic [ACC_W:0] raw_s;

  // full-width add; the extra bit is the carry out
  always_comb begin
    raw_s = {1'b0, acc} + {1'b0, addend};
    carry = raw_s[ACC_W];
`ifdef MUL_ACCUM_SATURATE_EN
    if (raw_s[ACC_W]) begin
      sum = {ACC_W{1'b1}};
    end else begin
      sum = raw_s[ACC_W-1:0];
    end
`else
    sum = raw_s[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/mul_accum.sv
// Sums a programmed number of 64-bit products and presents the result with
// a valid/ready handshake. Saturating build: define MUL_ACCUM_SATURATE_EN.
module mul_accum
  import mul_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic [PROD_W-1:0] prod,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  res,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              ovf,
  output logic              busy
);

  state_t             state_r, state_nxt_s;
  logic [ACC_W-1:0]   acc_r, acc_nxt_s, sum_s;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
  logic               ovf_r, ovf_nxt_s, carry_s, accept_s;

  mul_acc_add #(.ACC_W(ACC_W)) u_add (
    .acc    (acc_r),
    .addend ({{(ACC_W-PROD_W){1'b0}}, prod}),
    .sum    (sum_s),
    .carry  (carry_s)
  );

  assign accept_s = prod_valid & (state_r == ACCUM);

  // next-state and datapath update
  always_comb begin
    state_nxt_s = state_r;
    acc_nxt_s   = acc_r;
    cnt_nxt_s   = cnt_r;
    ovf_nxt_s   = ovf_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          acc_nxt_s   = {ACC_W{1'b0}};
          ovf_nxt_s   = 1'b0;
          cnt_nxt_s   = len;
          state_nxt_s = (len != {CNT_W{1'b0}}) ? ACCUM : HOLD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCUM: begin
        if (accept_s) begin
          acc_nxt_s = sum_s;
          cnt_nxt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          ovf_nxt_s = ovf_r | carry_s;
          if (cnt_r == {{(CNT_W-1){1'b0}}, 1'b1}) begin
            state_nxt_s = HOLD;
          end else begin
            state_nxt_s = ACCUM;
          end
        end else begin
          state_nxt_s = ACCUM;
        end
      end
      HOLD: begin
        if (res_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      acc_r   <= {ACC_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      acc_r   <= acc_nxt_s;
      cnt_r   <= cnt_nxt_s;
      ovf_r   <= ovf_nxt_s;
    end
  end

  // outputs decode straight from registers, no input-to-output path
  assign prod_ready = (state_r == ACCUM);
  assign res_valid  = (state_r == HOLD);
  assign busy       = (state_r != IDLE);
  assign res        = acc_r;
  assign ovf        = ovf_r;

endmodule

// File: tb/tb_mul_accum.sv
// Directed self-checking bench for mul_accum (default 72-bit and a 64-bit
// instance for overflow); expectations follow MUL_ACCUM_SATURATE_EN.
module tb_mul_accum;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = 8'd0;
  logic [63:0] prod = 64'd0;
  logic        prod_valid = 1'b0;
  logic        res_ready = 1'b0;

  logic        prod_ready, res_valid, ovf, busy;
  logic [71:0] res;
  logic        prod_ready64, res_valid64, ovf64, busy64;
  logic [63:0] res64;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mul_accum dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .prod(prod),
    .prod_valid(prod_valid), .prod_ready(prod_ready), .res(res),
    .res_valid(res_valid), .res_ready(res_ready), .ovf(ovf), .busy(busy)
  );

  mul_accum #(.ACC_W(64), .CNT_W(8)) dut64 (
    .clk(clk), .rst(rst), .start(start), .len(len), .prod(prod),
    .prod_valid(prod_valid), .prod_ready(prod_ready64), .res(res64),
    .res_valid(res_valid64), .res_ready(res_ready), .ovf(ovf64), .busy(busy64)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_start(input logic [7:0] n);
    start = 1'b1;
    len   = n;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input logic [63:0] p);
    prod       = p;
    prod_valid = 1'b1;
    tick();
    prod_valid = 1'b0;
  endtask

  task automatic drain();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    // reset
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_res", res, 72'd0);
    check("rst_res_valid", {71'd0, res_valid}, 72'd0);
    check("rst_prod_ready", {71'd0, prod_ready}, 72'd0);
    check("rst_busy", {71'd0, busy}, 72'd0);
    check("rst_ovf", {71'd0, ovf}, 72'd0);

    // basic run
    run_start(8'd3);
    check("basic_prod_ready", {71'd0, prod_ready}, 72'd1);
    check("basic_busy", {71'd0, busy}, 72'd1);
    feed(64'd119);
    check("basic_mid_valid", {71'd0, res_valid}, 72'd0);
    feed(64'd10);
    feed(64'd1);
    check("basic_res_valid", {71'd0, res_valid}, 72'd1);
    check("basic_res", res, 72'd130);
    check("basic_ovf", {71'd0, ovf}, 72'd0);
    check("basic_hold_ready", {71'd0, prod_ready}, 72'd0);
    drain();
    check("basic_idle_valid", {71'd0, res_valid}, 72'd0);
    check("basic_idle_busy", {71'd0, busy}, 72'd0);
    check("basic_res_kept", res, 72'd130);

    // backpressure on both sides
    run_start(8'd2);
    tick(); tick(); tick();
    check("bp_stall_acc", res, 72'd0);
    check("bp_stall_ready", {71'd0, prod_ready}, 72'd1);
    feed(64'd5);
    tick(); tick(); tick();
    check("bp_stall2_acc", res, 72'd5);
    check("bp_stall2_valid", {71'd0, res_valid}, 72'd0);
    feed(64'd6);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_res", res, 72'd11);
      check("bp_hold_valid", {71'd0, res_valid}, 72'd1);
      check("bp_hold_prod_ready", {71'd0, prod_ready}, 72'd0);
      tick();
    end
    drain();
    check("bp_idle", {71'd0, busy}, 72'd0);

    // zero length, with a product offered in HOLD that must be ignored
    run_start(8'd0);
    check("zero_valid", {71'd0, res_valid}, 72'd1);
    check("zero_res", res, 72'd0);
    check("zero_prod_ready", {71'd0, prod_ready}, 72'd0);
    feed(64'd99);
    check("zero_res_after_offer", res, 72'd0);
    drain();
    check("zero_idle", {71'd0, busy}, 72'd0);

    // reset mid-run
    run_start(8'd4);
    feed(64'd100);
    feed(64'd200);
    check("mid_partial", res, 72'd300);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy", {71'd0, busy}, 72'd0);
    check("mid_rst_res", res, 72'd0);
    check("mid_rst_ovf", {71'd0, ovf}, 72'd0);
    check("mid_rst_prod_ready", {71'd0, prod_ready}, 72'd0);
    run_start(8'd1);
    feed(64'd7);
    check("mid_new_valid", {71'd0, res_valid}, 72'd1);
    check("mid_new_res", res, 72'd7);
    drain();

    // spurious start while accumulating
    run_start(8'd2);
    feed(64'd1000);
    start = 1'b1;
    len   = 8'd9;
    tick();
    start = 1'b0;
    check("spur_still_accum", {71'd0, prod_ready}, 72'd1);
    check("spur_acc", res, 72'd1000);
    feed(64'd24);
    check("spur_valid", {71'd0, res_valid}, 72'd1);
    check("spur_res", res, 72'd1024);
    drain();
    check("spur_idle", {71'd0, busy}, 72'd0);

    // overflow: 64-bit instance wraps or saturates, 72-bit instance does not
    run_start(8'd3);
    feed(64'hFFFF_FFFF_FFFF_FFFF);
    feed(64'd2);
`ifdef MUL_ACCUM_SATURATE_EN
    check("ovf64_res", {8'd0, res64}, 72'h00_FFFF_FFFF_FFFF_FFFF);
`else
    check("ovf64_res", {8'd0, res64}, 72'd1);
`endif
    check("ovf64_flag", {71'd0, ovf64}, 72'd1);
    feed(64'd5);
    check("ovf64_valid", {71'd0, res_valid64}, 72'd1);
`ifdef MUL_ACCUM_SATURATE_EN
    check("ovf64_res_final", {8'd0, res64}, 72'h00_FFFF_FFFF_FFFF_FFFF);
`else
    check("ovf64_res_final", {8'd0, res64}, 72'd6);
`endif
    check("ovf64_sticky", {71'd0, ovf64}, 72'd1);
    check("wide_res", res, 72'h01_0000_0000_0000_0006);
    check("wide_ovf", {71'd0, ovf}, 72'd0);
    for (int i = 0; i < 3; i++) begin
      check("ovf64_hold_flag", {71'd0, ovf64}, 72'd1);
      tick();
    end
    drain();

    // next start clears the sticky flag
    run_start(8'd1);
    check("ovf64_cleared", {71'd0, ovf64}, 72'd0);
    feed(64'd3);
    check("ovf64_next_res", {8'd0, res64}, 72'd3);
    check("ovf64_next_flag", {71'd0, ovf64}, 72'd0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
